// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the signed-overflow output).
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to represent WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial adder's per-cycle arithmetic stage.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per cycle, LSB first, WIDTH cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    full_adder u_full_adder (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Result enters at the MSB so that after WIDTH shifts bit 0 sits at sum_q[0].
    assign sum_d = {fa_s, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        cout_q  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q here is the carry into the MSB.
                        ovf_q   <= carry_q ^ fa_co;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with an arithmetic reference model and scoreboard.
// Covers the ovf output when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c);
        int unsigned u;
        int          s;
        logic        o;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        o = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
        return {o, u[W], u[W-1:0]};
    endfunction

    // Timing model: an accepted op is busy for W cycles, then done for one cycle.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] res;
    bit           active    = 0;
    bit           seen_edge = 0;
    int           k         = 0;

    always @(posedge clk) begin
        seen_edge = 1;
        if (!rst_n) begin
            active = 0;
            k      = 0;
            res    = '0;
            exp_q.delete();
        end else if (active) begin
            k++;
            if (k == W + 1) begin
                if (exp_q.size() > 0) res = exp_q.pop_front();
            end
            if (k == W + 2) active = 0;
        end else if (start) begin
            active = 1;
            k      = 1;
            exp_q.push_back(model_add(a, b, cin));
        end
    end

    always @(negedge clk) begin
        if (seen_edge) begin
            logic exp_busy;
            logic exp_done;
            exp_busy = active && (k <= W);
            exp_done = active && (k == W + 1);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (!exp_busy) begin
                check("sum", sum, res[W-1:0]);
                check("cout", cout, res[W]);
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", ovf, res[W+1]);
`endif
            end
        end
    end

    // One operation from IDLE; poke=1 pulses start with junk operands at cycles 3 and 9.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input bit poke, input string tag);
        int done_at;
        int n_done;
        check({tag, "_model"}, model_add(xa, xb, xc), {eo, ec, es});
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
        done_at = 0;
        n_done  = 0;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a     = W'($urandom_range(0, 255));
                b     = W'($urandom_range(0, 255));
                cin   = 1'($urandom_range(0, 1));
            end
            if (poke && (i == 3 || i == 9)) begin
                start = 1'b1; a = '1; b = '1; cin = 1'b1;
            end
            if (poke && (i == 4 || i == 10)) start = 1'b0;
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = i;
            end
        end
        check({tag, "_latency"}, done_at, W + 1);
        check({tag, "_ndone"}, n_done, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, ovf, eo);
`endif
    endtask

    task automatic reset_abort();
        int done_at;
        int n_done;
        @(negedge clk);
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        done_at = 0;
        n_done  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; a = 8'hEE; b = 8'hDD;
            end
            if (i == 4) rst_n = 1'b0;
            if (i == 5) begin
                check("abort_busy", busy, 0);
                check("abort_sum", sum, 0);
                check("abort_cout", cout, 0);
                rst_n = 1'b1;
                a = 8'h21; b = 8'h21; cin = 1'b0; start = 1'b1;
            end
            if (i == 6) start = 1'b0;
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = i;
            end
        end
        check("abort_done_at", done_at, 5 + W + 1);
        check("abort_ndone", n_done, 1);
        check("abort_new_sum", sum, 8'h42);
        check("abort_new_cout", cout, 0);
    endtask

    task automatic back_to_back();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vc [3];
        logic [W-1:0] vs [3];
        logic         vco[3];
        int           done_at;
        logic [W-1:0] sum_at_done;
        va = '{8'h01, 8'hC8, 8'h99};
        vb = '{8'h02, 8'h64, 8'h99};
        vc = '{1'b0, 1'b1, 1'b1};
        vs = '{8'h03, 8'h2D, 8'h33};
        vco = '{1'b0, 1'b1, 1'b1};
        @(negedge clk);
        a = va[0]; b = vb[0]; cin = vc[0]; start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            done_at     = 0;
            sum_at_done = '0;
            for (int i = 1; i <= W + 2; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    a = W'($urandom_range(0, 255));
                    b = W'($urandom_range(0, 255));
                end
                if (done && done_at == 0) begin
                    done_at     = i;
                    sum_at_done = sum;
                end
                if (i == W + 2) begin
                    if (op < 2) begin
                        a = va[op+1]; b = vb[op+1]; cin = vc[op+1];
                    end else begin
                        start = 1'b0;
                    end
                end
            end
            check($sformatf("b2b%0d_done_at", op), done_at, W + 1);
            check($sformatf("b2b%0d_sum", op), sum_at_done, vs[op]);
            check($sformatf("b2b%0d_cout", op), cout, vco[op]);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, "op0f_01");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "opff_01");
        do_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0, "op00_cin");
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "op7f_01");
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, "op80_80");
        do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0, "opa5_5a");
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1, "ignore");
        reset_abort();
        back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
